// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 20-bit ALU: handshaked request in, result out,
// iterated 1-bit shift/rotate, owns the {S,Z,C} status register and trap.
module alu_seq_ctrl #(
  parameter int         WIDTH      = 20,
  parameter int         AMT_W      = 5,
  parameter logic [2:0] STATUS_RST = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       status,
  output logic             busy,
  output logic             trap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SBC  = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;
  localparam logic [3:0] OP_LSR  = 4'd13;
  localparam logic [3:0] OP_XSR  = 4'd14;
  localparam logic [3:0] OP_TRAP = 4'd15;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       st_q, st_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;

  function automatic logic [2:0] flags(
    input logic [WIDTH-1:0] r,
    input logic             c
  );
    return {r[WIDTH-1], ~|r, c};
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHR) || (op == OP_SHL) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // One shared 1-bit step unit; fed from the request on accept, else from the working reg.
  logic [3:0]       stp_op;
  logic [WIDTH-1:0] stp_x, stp_y;
  logic             stp_ci, stp_co;

  always_comb begin
    stp_op = (state_q == S_IDLE) ? req_op : op_q;
    stp_x  = (state_q == S_IDLE) ? req_a : res_q;
    stp_ci = (state_q == S_IDLE) ? st_q[0] : c_q;
    stp_y  = stp_x;
    stp_co = stp_ci;
    case (stp_op)
      OP_SHR: begin
        stp_y  = {stp_x[WIDTH-2:0], 1'b0};
        stp_co = stp_x[WIDTH-1];
      end
      OP_SHL: begin
        stp_y  = {1'b0, stp_x[WIDTH-1:1]};
        stp_co = stp_x[0];
      end
      OP_ROR: stp_y = {stp_x[WIDTH-2:0], stp_x[WIDTH-1]};
      OP_ROL: stp_y = {stp_x[0], stp_x[WIDTH-1:1]};
      default: ;
    endcase
  end

  logic [WIDTH-1:0] alu_r;
  logic [2:0]       alu_st;
  logic [WIDTH:0]   sum;

  always_comb begin
    alu_r  = '0;
    alu_st = st_q;
    sum    = '0;
    case (req_op)
      OP_NOT: begin
        alu_r  = ~req_a;
        alu_st = flags(alu_r, st_q[0]);
      end
      OP_AND: begin
        alu_r  = req_a & req_b;
        alu_st = flags(alu_r, st_q[0]);
      end
      OP_OR: begin
        alu_r  = req_a | req_b;
        alu_st = flags(alu_r, st_q[0]);
      end
      OP_XOR: begin
        alu_r  = req_a ^ req_b;
        alu_st = flags(alu_r, st_q[0]);
      end
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
        alu_r  = req_a;
        alu_st = flags(alu_r, st_q[0]);
      end
      OP_INC: begin
        sum    = {1'b0, req_a} + (WIDTH+1)'(1);
        alu_r  = sum[WIDTH-1:0];
        alu_st = flags(alu_r, sum[WIDTH]);
      end
      OP_SUB: begin
        sum    = {1'b0, req_a} - {1'b0, req_b};
        alu_r  = sum[WIDTH-1:0];
        alu_st = flags(alu_r, sum[WIDTH]);
      end
      OP_SBC: begin
        sum    = {1'b0, req_a} - {1'b0, req_b}
               - {{WIDTH{1'b0}}, st_q[0]};
        alu_r  = sum[WIDTH-1:0];
        alu_st = flags(alu_r, sum[WIDTH]);
      end
      OP_CMP: begin
        alu_r  = req_a;
        alu_st = {req_a < req_b, req_a == req_b, st_q[0]};
      end
      OP_LSR: begin
        alu_st = req_a[2:0];
        alu_r  = {{(WIDTH-3){1'b0}}, alu_st};
      end
      OP_XSR: begin
        alu_st = st_q ^ req_a[2:0];
        alu_r  = {{(WIDTH-3){1'b0}}, alu_st};
      end
      OP_TRAP: alu_r = req_a;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          // First shift step happens on the accept edge so amt=N costs N cycles.
          if (is_shift(req_op) && (|req_amt)) begin
            res_d = stp_y;
            c_d   = stp_co;
            cnt_d = req_amt - AMT_W'(1);
            if (req_amt == AMT_W'(1)) begin
              state_d = S_DONE;
              st_d    = flags(stp_y, stp_co);
            end else begin
              state_d = S_EXEC;
            end
          end else begin
            res_d   = alu_r;
            st_d    = alu_st;
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        res_d = stp_y;
        c_d   = stp_co;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
          st_d    = flags(stp_y, stp_co);
        end
      end
      S_DONE: begin
        if (rsp_ready)
          state_d = (op_q == OP_TRAP) ? S_TRAP : S_IDLE;
      end
      S_TRAP: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      res_q   <= '0;
      st_q    <= STATUS_RST;
      cnt_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign trap       = (state_q == S_TRAP);
  assign rsp_result = res_q;
  assign status     = st_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: vector table with scoreboard queue,
// plus stall, trap and mid-operation reset sequences.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [19:0] req_a;
  logic [19:0] req_b;
  logic [4:0]  req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_result;
  logic [2:0]  status;
  logic        busy;
  logic        trap;

  alu_seq_ctrl #(
    .WIDTH(20),
    .AMT_W(5),
    .STATUS_RST(3'b000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_amt(req_amt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .status(status),
    .busy(busy),
    .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [19:0] a;
    logic [19:0] b;
    logic [4:0]  amt;
    logic [19:0] res;
    logic [2:0]  st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [19:0] res;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[21];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, " rsp_result"}, 32'(rsp_result), 32'(0));
    chk({tag, " status"}, 32'(status), 32'(0));
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " trap"}, 32'(trap), 32'(0));
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic accept(input vec_t v);
    int w = 0;
    exp_t e;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready before accept", 32'(req_ready), 32'(1));
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_amt   = v.amt;
    @(posedge clk);
    e.res = v.res;
    e.st  = v.st;
    sb.push_back(e);
  endtask

  task automatic await_rsp(input int exp_lat);
    int   lat = 0;
    exp_t e;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (!rsp_valid) chk("busy in flight", 32'(busy), 32'(1));
    end while (!rsp_valid && lat < 64);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL scoreboard: response with nothing expected");
    end else begin
      e = sb.pop_front();
      chk("rsp_result", 32'(rsp_result), 32'(e.res));
      chk("status", 32'(status), 32'(e.st));
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run(input vec_t v);
    accept(v);
    await_rsp(v.lat);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // op, a, b, amt, result, {S,Z,C}, latency
    tbl[0]  = '{4'd6,  20'h00001, 20'h00000, 5'd1,  20'h00000, 3'b011, 1};
    tbl[1]  = '{4'd5,  20'h80001, 20'h00000, 5'd3,  20'h00008, 3'b000, 3};
    tbl[2]  = '{4'd10, 20'h00005, 20'h00007, 5'd0,  20'hFFFFE, 3'b101, 1};
    tbl[3]  = '{4'd11, 20'h0000A, 20'h00002, 5'd0,  20'h00007, 3'b000, 1};
    tbl[4]  = '{4'd9,  20'hFFFFF, 20'h00000, 5'd0,  20'h00000, 3'b011, 1};
    tbl[5]  = '{4'd8,  20'h12345, 20'h00000, 5'd20, 20'h12345, 3'b001, 20};
    tbl[6]  = '{4'd2,  20'hFF00F, 20'h0F0F1, 5'd0,  20'h0F001, 3'b001, 1};
    tbl[7]  = '{4'd3,  20'h80000, 20'h00001, 5'd0,  20'h80001, 3'b101, 1};
    tbl[8]  = '{4'd4,  20'hABCDE, 20'hABCDE, 5'd0,  20'h00000, 3'b011, 1};
    tbl[9]  = '{4'd1,  20'h00000, 20'h00000, 5'd0,  20'hFFFFF, 3'b101, 1};
    tbl[10] = '{4'd12, 20'h00003, 20'h00009, 5'd0,  20'h00003, 3'b101, 1};
    tbl[11] = '{4'd12, 20'h00009, 20'h00009, 5'd0,  20'h00009, 3'b011, 1};
    tbl[12] = '{4'd0,  20'h12345, 20'h00000, 5'd0,  20'h00000, 3'b011, 1};
    tbl[13] = '{4'd5,  20'h80000, 20'h00000, 5'd0,  20'h80000, 3'b101, 1};
    tbl[14] = '{4'd6,  20'hFFFFF, 20'h00000, 5'd25, 20'h00000, 3'b010, 25};
    tbl[15] = '{4'd7,  20'h00001, 20'h00000, 5'd4,  20'h00010, 3'b000, 4};
    tbl[16] = '{4'd11, 20'h00000, 20'h00000, 5'd0,  20'h00000, 3'b010, 1};
    tbl[17] = '{4'd10, 20'h00000, 20'h00001, 5'd0,  20'hFFFFF, 3'b101, 1};
    tbl[18] = '{4'd11, 20'h00000, 20'h00000, 5'd0,  20'hFFFFF, 3'b101, 1};
    tbl[19] = '{4'd13, 20'h00005, 20'h00000, 5'd0,  20'h00005, 3'b101, 1};
    tbl[20] = '{4'd14, 20'h00007, 20'h00000, 5'd0,  20'h00002, 3'b010, 1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 21; i++) run(tbl[i]);

    // Response stall with a stray request that must not be taken.
    v = '{4'd2, 20'hFFFFF, 20'h12345, 5'd0, 20'h12345, 3'b000, 1};
    accept(v);
    await_rsp(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = (k == 1);
      req_op    = 4'd1;
      req_a     = 20'h00000;
      chk("stall rsp_valid", 32'(rsp_valid), 32'(1));
      chk("stall rsp_result", 32'(rsp_result), 32'(20'h12345));
      chk("stall status", 32'(status), 32'(3'b000));
    end
    req_valid = 1'b0;
    handshake();
    chk("post-stall rsp_valid", 32'(rsp_valid), 32'(0));
    chk("post-stall req_ready", 32'(req_ready), 32'(1));

    // Trap: sticky until reset, requests ignored.
    v = '{4'd15, 20'hABCDE, 20'h00000, 5'd0, 20'hABCDE, 3'b000, 1};
    accept(v);
    await_rsp(1);
    chk("trap before hs", 32'(trap), 32'(0));
    handshake();
    chk("trap", 32'(trap), 32'(1));
    chk("trap req_ready", 32'(req_ready), 32'(0));
    chk("trap busy", 32'(busy), 32'(1));
    req_valid = 1'b1;
    req_op    = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("trap held", 32'(trap), 32'(1));
    chk("trap rsp_valid", 32'(rsp_valid), 32'(0));
    chk("trap status", 32'(status), 32'(3'b000));

    rst = 1'b1;
    @(negedge clk);
    chk_reset("trap reset");
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a long shift.
    v = '{4'd5, 20'h12345, 20'h00000, 5'd10, 20'h00000, 3'b000, 10};
    accept(v);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid-shift busy", 32'(busy), 32'(1));
      chk("mid-shift rsp_valid", 32'(rsp_valid), 32'(0));
    end
    #2 rst = 1'b1;
    #1 chk_reset("async reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run('{4'd9, 20'h00001, 20'h00000, 5'd0, 20'h00002, 3'b000, 1});

    chk("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
